// File: rtl/csel_a64.sv
// 64-bit carry-select adder (16 x 4-bit stages) with a registered sum/carry-out.
// Optional carry-in port enabled by defining CSELA64_CIN_EN.
module csel_a64 (
    output logic [63:0] sum,
    output logic        cout,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        clk,
    input  logic        rst
`ifdef CSELA64_CIN_EN
    ,
    input  logic        cin
`endif
);

    // Returns {carry_out, sum[3:0]} of a 4-bit ripple adder built from full adders.
    function automatic logic [4:0] rca4(input logic [3:0] x, input logic [3:0] y, input logic c_in);
        logic [3:0] s;
        logic       c;
        c = c_in;
        for (int i = 0; i < 4; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    logic [16:0] w_carry;
    logic [63:0] w_sum;
    logic [4:0]  w_res0 [1:15];
    logic [4:0]  w_res1 [1:15];

`ifdef CSELA64_CIN_EN
    assign w_carry[0] = cin;
`else
    assign w_carry[0] = 1'b0;
`endif

    assign {w_carry[1], w_sum[3:0]} = rca4(a[3:0], b[3:0], w_carry[0]);

    // Each upper stage precomputes both carry-in cases; only the mux sits on the carry path.
    for (genvar k = 1; k < 16; k++) begin : g_stage
        assign w_res0[k] = rca4(a[4*k+3:4*k], b[4*k+3:4*k], 1'b0);
        assign w_res1[k] = rca4(a[4*k+3:4*k], b[4*k+3:4*k], 1'b1);
        assign {w_carry[k+1], w_sum[4*k+3:4*k]} = w_carry[k] ? w_res1[k] : w_res0[k];
    end

    logic [63:0] r_sum;
    logic        r_cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= 64'h0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_carry[16];
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_csel_a64.sv
// Scoreboard bench for csel_a64: 65-bit reference sum queued on issue, popped by a monitor.
module tb_csel_a64;

    logic        clk;
    logic        rst;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin_v;
    logic [63:0] sum;
    logic        cout;

    int total;
    int bad;
    logic [64:0] sb[$];

    csel_a64 dut (
        .sum  (sum),
        .cout (cout),
        .a    (a),
        .b    (b),
        .clk  (clk),
        .rst  (rst)
`ifdef CSELA64_CIN_EN
        ,
        .cin  (cin_v)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got cout=%b sum=%h, expected cout=%b sum=%h",
                     name, act[64], act[63:0], exp[64], exp[63:0]);
        end
    endtask

    // Reference: plain 65-bit unsigned addition.
    function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y, input logic c);
        logic [64:0] r;
        r = {1'b0, x} + {1'b0, y};
`ifdef CSELA64_CIN_EN
        r = r + {64'h0, c};
`endif
        return r;
    endfunction

    task automatic apply(input logic [63:0] x, input logic [63:0] y, input logic c);
        a = x;
        b = y;
        cin_v = c;
        sb.push_back(ref_add(x, y, c));
    endtask

    task automatic step(input logic [63:0] x, input logic [63:0] y, input logic c);
        @(posedge clk);
        #2;
        apply(x, y, c);
    endtask

    // Raise reset between edges and confirm the asynchronous clear before any clock edge.
    task automatic rst_pulse(input int hold_cycles);
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("async_clear", {cout, sum}, 65'h0);
        repeat (hold_cycles) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: zeros while in reset, otherwise the oldest queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("reset_hold", {cout, sum}, 65'h0);
            end else if (sb.size() > 0) begin
                check("result", {cout, sum}, sb.pop_front());
            end
        end
    end

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        a = 64'd5;
        b = 64'd7;
        cin_v = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_initial", {cout, sum}, 65'h0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        apply(64'd5, 64'd7, 1'b0);

        step(64'd998, 64'd128, 1'b0);
        step(64'd9998, 64'd9028, 1'b0);
        step(64'd9989998, 64'd769028, 1'b0);
        step(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        step(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step(64'h0000_0000_0000_000F, 64'd1, 1'b0);
        step(64'h0FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        step(64'h0, 64'h0, 1'b0);
`ifdef CSELA64_CIN_EN
        step(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        step(64'd3, 64'd4, 1'b1);
`endif

        // Load a nonzero result so the mid-stream clear is observable.
        step(64'd5, 64'd7, 1'b0);
        rst_pulse(2);
        apply(64'd5, 64'd7, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            logic [63:0] x;
            logic [63:0] y;
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if ($urandom_range(15) == 0) y = ~x;
            if (i == 5000) begin
                step(x, y, 1'($urandom_range(1)));
                rst_pulse(3);
                apply(y, x, 1'($urandom_range(1)));
            end else begin
                step(x, y, 1'($urandom_range(1)));
            end
        end

        @(posedge clk);
        #3;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
